// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator for the word-addressed data RAM, serving RV32I loads and stores
//   from the EX/MEM stage. The unit handles one request at a time. Every RAM
//   access is a full word. Byte and half loads are extracted from that word and
//   then sign- or zero-extended. The RAM has no byte strobes, so SB and SH are
//   done as read-modify-write.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake; ready only while idle
//   req_we, req_funct3          store select, RV32I width/sign code
//   req_addr, req_wdata         byte address, store data
//   resp_valid                  one-cycle completion pulse
//   resp_rdata, resp_err        load result / error flag, valid with resp_valid
//   mem_read_en, mem_write_en   registered RAM enables, never both high
//   mem_load_type               constant word access
//   mem_addr, mem_wdata         registered word index and write word
//   mem_rdata                   RAM read data, one cycle after mem_read_en
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready; latch request, classify, flag errors
// RD_ISSUE | mem_read_en high for one cycle
// RD_WAIT  | mem_rdata valid; extract load result or merge SB/SH lane
// WR_ISSUE | mem_write_en high for one cycle
// DONE     | resp_valid high for one cycle
module load_store_unit #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_DEPTH_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_read_en,
   output logic                  mem_write_en,
   output logic [1:0]            mem_load_type,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_ISSUE = 3'd1,
      S_RD_WAIT  = 3'd2,
      S_WR_ISSUE = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t state_q, state_nxt;

   logic        we_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic [15:0] wdata_q;

   logic                  accept;
   logic                  req_err;
   logic                  illegal_f3;
   logic                  misaligned;
   logic                  out_of_range;
   logic [ADDR_WIDTH-3:0] req_word_idx;

   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [DATA_WIDTH-1:0] load_val;
   logic [DATA_WIDTH-1:0] merge_val;

   assign req_ready     = (state_q == S_IDLE);
   assign accept        = req_valid & req_ready;
   assign mem_load_type = 2'b00;
   assign req_word_idx  = req_addr[ADDR_WIDTH-1:2];

   // Request classification, evaluated on the raw request in IDLE.
   always_comb begin
      illegal_f3 = 1'b0;
      misaligned = 1'b0;
      if (req_we) begin
         illegal_f3 = (req_funct3 > 3'b010);
      end else begin
         illegal_f3 = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 ||
                        req_funct3 == 3'b010 || req_funct3 == 3'b100 ||
                        req_funct3 == 3'b101);
      end
      case (req_funct3[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = (req_addr[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   // Any bit above the RAM index width means the word does not exist.
   assign out_of_range = ((req_word_idx >> MEM_DEPTH_LOG2) != '0);
   assign req_err      = illegal_f3 | misaligned | out_of_range;

   // Lane selection from the returned word.
   always_comb begin
      rd_byte = mem_rdata[7:0];
      case (off_q)
         2'd0:    rd_byte = mem_rdata[7:0];
         2'd1:    rd_byte = mem_rdata[15:8];
         2'd2:    rd_byte = mem_rdata[23:16];
         default: rd_byte = mem_rdata[31:24];
      endcase
      rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   always_comb begin
      load_val = '0;
      case (funct3_q)
         3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
         3'b010:  load_val = mem_rdata;
         3'b100:  load_val = {24'd0, rd_byte};
         3'b101:  load_val = {16'd0, rd_half};
         default: load_val = '0;
      endcase
   end

   // Read-modify-write: only the addressed lane takes store data.
   always_comb begin
      merge_val = mem_rdata;
      if (funct3_q[1:0] == 2'b00) begin
         case (off_q)
            2'd0:    merge_val[7:0]   = wdata_q[7:0];
            2'd1:    merge_val[15:8]  = wdata_q[7:0];
            2'd2:    merge_val[23:16] = wdata_q[7:0];
            default: merge_val[31:24] = wdata_q[7:0];
         endcase
      end else if (off_q[1]) begin
         merge_val[31:16] = wdata_q;
      end else begin
         merge_val[15:0] = wdata_q;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (req_err)
                  state_nxt = S_DONE;
               else if (req_we && req_funct3 == 3'b010)
                  state_nxt = S_WR_ISSUE;
               else
                  state_nxt = S_RD_ISSUE;
            end
         end
         S_RD_ISSUE: state_nxt = S_RD_WAIT;
         S_RD_WAIT:  state_nxt = we_q ? S_WR_ISSUE : S_DONE;
         S_WR_ISSUE: state_nxt = S_DONE;
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_nxt;
   end

   // Enables and resp_valid are decoded from the next state. Each is then a
   // clean register that is high exactly while the FSM sits in its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         wdata_q      <= 16'd0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
         resp_rdata   <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         mem_read_en  <= (state_nxt == S_RD_ISSUE);
         mem_write_en <= (state_nxt == S_WR_ISSUE);
         resp_valid   <= (state_nxt == S_DONE);
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  we_q       <= req_we;
                  funct3_q   <= req_funct3;
                  off_q      <= req_addr[1:0];
                  wdata_q    <= req_wdata[15:0];
                  resp_err   <= req_err;
                  resp_rdata <= '0;
                  if (!req_err) begin
                     mem_addr <= {2'b00, req_word_idx};
                     if (req_we)
                        mem_wdata <= req_wdata;
                  end
               end
            end
            S_RD_WAIT: begin
               if (we_q)
                  mem_wdata <= merge_val;
               else
                  resp_rdata <= load_val;
            end
            S_DONE: begin
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [1:0]  mem_load_type;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'd0;

   int vectors = 0;
   int miscompares = 0;
   int overlap = 0;
   int ltype_bad = 0;

   logic [31:0] ram [32] = '{default: 32'd0};
   logic [31:0] ref_mem [32];

   load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_LOG2(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_load_type(mem_load_type), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: write on the edge, read data one cycle after read enable.
   always @(posedge clk) begin
      if (mem_write_en) ram[mem_addr[4:0]] <= mem_wdata;
      if (mem_read_en) mem_rdata <= ram[mem_addr[4:0]];
   end

   always @(negedge clk) begin
      if (mem_read_en && mem_write_en) overlap++;
      if (mem_load_type !== 2'b00) ltype_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Behavioural model of one request, built from the RV32I rules directly.
   task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic err, output logic [31:0] rd,
                            output logic [31:0] nword, output int lat, output int nr,
                            output int nw);
      int unsigned idx, sh, sz;
      logic [31:0] word, v, m;
      bit legal;
      sz = f3 % 4;
      legal = we ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      err = !legal || (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0) ||
            (addr / 4 >= 32);
      idx = (addr / 4) % 32;
      word = ref_mem[idx];
      nword = word;
      rd = 32'd0;
      if (err) begin
         lat = 1; nr = 0; nw = 0;
      end else if (!we) begin
         lat = 3; nr = 1; nw = 0;
         sh = 8 * (addr % 4);
         if (sz == 0) begin
            v = (word >> sh) & 32'hFF;
            if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
         end else if (sz == 1) begin
            v = (word >> sh) & 32'hFFFF;
            if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
         end else begin
            v = word;
         end
         rd = v;
      end else if (sz == 2) begin
         lat = 2; nr = 0; nw = 1;
         nword = wd;
      end else begin
         lat = 4; nr = 1; nw = 1;
         sh = 8 * (addr % 4);
         m = (sz == 0) ? 32'hFF : 32'hFFFF;
         nword = (word & ~(m << sh)) | ((wd & m) << sh);
      end
      if (!err && we) ref_mem[idx] = nword;
   endtask

   task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold);
      logic e_err; logic [31:0] e_rd, e_word;
      int e_lat, e_nr, e_nw;
      int lat, nr, nw;
      bit got, busy_ready, addr_bad;
      logic [31:0] g_rd, w_seen;
      logic g_err;
      ref_model(we, f3, addr, wd, e_err, e_rd, e_word, e_lat, e_nr, e_nw);
      @(negedge clk);
      chk("ready_idle", req_ready, 1'b1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
      lat = 0; nr = 0; nw = 0; got = 0; busy_ready = 0; addr_bad = 0;
      g_rd = 32'd0; g_err = 1'b0; w_seen = 32'd0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         lat++;
         if (req_ready) busy_ready = 1;
         if (mem_read_en) begin
            nr++;
            if (mem_addr !== addr / 4) addr_bad = 1;
         end
         if (mem_write_en) begin
            nw++;
            w_seen = mem_wdata;
            if (mem_addr !== addr / 4) addr_bad = 1;
         end
         if (resp_valid) begin
            got = 1; g_rd = resp_rdata; g_err = resp_err;
         end
      end
      req_valid = 1'b0;
      chk("resp_seen", got, 1'b1);
      chk("latency", lat, e_lat);
      chk("resp_rdata", g_rd, e_rd);
      chk("resp_err", g_err, e_err);
      chk("read_cycles", nr, e_nr);
      chk("write_cycles", nw, e_nw);
      chk("ready_busy", busy_ready, 1'b0);
      chk("mem_addr", addr_bad, 1'b0);
      if (e_nw != 0) chk("write_word", w_seen, e_word);
      @(negedge clk);
      chk("resp_pulse", resp_valid, 1'b0);
   endtask

   initial begin
      int wr_seen;
      bit hold;
      logic [31:0] a;
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;

      #12;
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_mem_read_en", mem_read_en, 1'b0);
      chk("rst_mem_write_en", mem_write_en, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", resp_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1'b1);

      // Directed sequence from the worked examples.
      do_op(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 0);
      do_op(1'b0, 3'b010, 32'h08, 32'h0, 0);
      do_op(1'b1, 3'b000, 32'h09, 32'h55, 1);
      do_op(1'b0, 3'b000, 32'h09, 32'h0, 0);
      do_op(1'b0, 3'b100, 32'h0B, 32'h0, 0);
      do_op(1'b0, 3'b010, 32'h08, 32'h0, 0);
      do_op(1'b1, 3'b001, 32'h0E, 32'h8001, 0);
      do_op(1'b0, 3'b001, 32'h0E, 32'h0, 0);
      do_op(1'b0, 3'b101, 32'h0E, 32'h0, 0);
      do_op(1'b0, 3'b010, 32'h0C, 32'h0, 0);
      do_op(1'b0, 3'b010, 32'h02, 32'h0, 0);
      do_op(1'b1, 3'b001, 32'h03, 32'h1234, 0);
      do_op(1'b0, 3'b010, 32'h80, 32'h0, 0);
      do_op(1'b0, 3'b011, 32'h00, 32'h0, 0);
      do_op(1'b1, 3'b011, 32'h00, 32'h0, 0);
      do_op(1'b1, 3'b010, 32'h7C, 32'hCAFEF00D, 0);
      do_op(1'b0, 3'b010, 32'h7C, 32'h0, 0);
      do_op(1'b0, 3'b000, 32'h7F, 32'h0, 0);

      // Reset during the read phase of an SB must leave the RAM word intact.
      do_op(1'b1, 3'b010, 32'h14, 32'h12345678, 0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h15; req_wdata = 32'hAA;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("rmw_no_write_yet", mem_write_en, 1'b0);
      rst_n = 1'b0;
      #1;
      req_valid = 1'b0;
      chk("abort_resp_valid", resp_valid, 1'b0);
      chk("abort_mem_read_en", mem_read_en, 1'b0);
      chk("abort_mem_write_en", mem_write_en, 1'b0);
      chk("abort_mem_addr", mem_addr, 32'd0);
      chk("abort_mem_wdata", mem_wdata, 32'd0);
      wr_seen = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (mem_write_en) wr_seen++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (mem_write_en) wr_seen++;
      end
      chk("abort_no_write", wr_seen, 0);
      chk("abort_ram_word", ram[5], 32'h12345678);
      chk("abort_ready", req_ready, 1'b1);
      do_op(1'b0, 3'b010, 32'h14, 32'h0, 0);

      // Randomized traffic against the model.
      for (int n = 0; n < 200; n++) begin
         a = ($urandom % 8 == 0) ? $urandom : 32'($urandom_range(0, 32'h9F));
         hold = ($urandom % 4 == 0);
         do_op(1'($urandom % 2), 3'($urandom % 8), a, $urandom, hold);
      end

      for (int i = 0; i < 32; i++) chk("ram_final", ram[i], ref_mem[i]);
      chk("enable_overlap", overlap, 0);
      chk("load_type", ltype_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
